// File: rtl/snn_pkg.sv
// Shared defaults and helpers for the LIF oscillator network: widths, threshold,
// saturating clamp and the weight-address mapping.
package snn_pkg;

  localparam int SNN_N_NEURONS  = 4;
  localparam int SNN_V_WIDTH    = 8;
  localparam int SNN_W_WIDTH    = 8;
  localparam int SNN_THRESH     = 128;
  localparam int SNN_LEAK_SHIFT = 3;
  localparam int SNN_REFRAC     = 4;

  // Clamp a signed sum into the unsigned membrane range [0, 2^vw-1].
  function automatic logic [31:0] sat_u(input logic signed [31:0] x, input int vw);
    logic signed [31:0] vmax;
    vmax = (32'sd1 <<< vw) - 32'sd1;
    if (x < 0)         return 32'd0;
    else if (x > vmax) return 32'(vmax);
    else               return 32'(x);
  endfunction

  // Flat weight index: row = destination neuron, column = source neuron.
  function automatic int widx(input int dst, input int src, input int n);
    return dst * n + src;
  endfunction

endpackage

// File: rtl/lif_neuron.sv
// One leaky integrate-and-fire neuron: membrane register, refractory counter and
// registered spike. Synaptic input arrives pre-summed from the parent network.
module lif_neuron
  import snn_pkg::*;
#(
  parameter int V_WIDTH    = SNN_V_WIDTH,
  parameter int SW         = SNN_V_WIDTH + 4,
  parameter int THRESH     = SNN_THRESH,
  parameter int LEAK_SHIFT = SNN_LEAK_SHIFT,
  parameter int REFRAC     = SNN_REFRAC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [V_WIDTH-1:0]   bias,
  input  logic signed [SW-1:0] syn_in,
  output logic                 spike,
  output logic                 spike_next,
  output logic [V_WIDTH-1:0]   v_out
);

  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam logic [V_WIDTH:0] TH = (V_WIDTH + 1)'(THRESH);

  logic [V_WIDTH-1:0]   v_q;
  logic [RW-1:0]        refrac_q;
  logic signed [SW-1:0] sum;
  logic [V_WIDTH-1:0]   v_next;
  logic                 fire;

  always_comb begin
    sum = $signed({{(SW - V_WIDTH){1'b0}}, v_q})
        - $signed({{(SW - V_WIDTH){1'b0}}, v_q >> LEAK_SHIFT})
        + $signed({{(SW - V_WIDTH){1'b0}}, bias})
        + syn_in;
    v_next     = V_WIDTH'(sat_u(32'(sum), V_WIDTH));
    fire       = ({1'b0, v_next} >= TH);
    spike_next = ena && (refrac_q == '0) && fire;
  end

  // ena low freezes v and refrac but still clears the pulse so it never repeats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q      <= '0;
      refrac_q <= '0;
      spike    <= 1'b0;
    end else if (!ena) begin
      spike <= 1'b0;
    end else if (refrac_q != '0) begin
      v_q      <= '0;
      refrac_q <= refrac_q - 1'b1;
      spike    <= 1'b0;
    end else if (fire) begin
      v_q      <= '0;
      refrac_q <= RW'(REFRAC);
      spike    <= 1'b1;
    end else begin
      v_q   <= v_next;
      spike <= 1'b0;
    end
  end

  assign v_out = v_q;

endmodule

// File: rtl/snn_oscillator_net.sv
// N-neuron LIF network with a programmable signed all-to-all coupling matrix.
// Owns the weight file, per-neuron synaptic adders and the spike-cycle counter.
module snn_oscillator_net
  import snn_pkg::*;
#(
  parameter int N_NEURONS  = SNN_N_NEURONS,
  parameter int V_WIDTH    = SNN_V_WIDTH,
  parameter int W_WIDTH    = SNN_W_WIDTH,
  parameter int THRESH     = SNN_THRESH,
  parameter int LEAK_SHIFT = SNN_LEAK_SHIFT,
  parameter int REFRAC     = SNN_REFRAC
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ena,
  input  logic [N_NEURONS*V_WIDTH-1:0]   bias_in,
  input  logic                           cfg_we,
  input  logic [$clog2(N_NEURONS*N_NEURONS)-1:0] cfg_addr,
  input  logic [W_WIDTH-1:0]             cfg_wdata,
  output logic [N_NEURONS-1:0]           spike_out,
  output logic                           spike_any,
  output logic [7:0]                     spike_count
);

  localparam int AW = $clog2(N_NEURONS * N_NEURONS);
  localparam int SW = V_WIDTH + $clog2(N_NEURONS) + 2;

  // Sized to the full address space so any cfg_addr is a legal index.
  logic signed [W_WIDTH-1:0] w_q [2**AW];
  logic signed [SW-1:0]      syn [N_NEURONS];
  logic [N_NEURONS-1:0]      spike_next;
  logic [V_WIDTH-1:0]        v_dbg [N_NEURONS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2**AW; k++) w_q[k] <= '0;
    end else if (cfg_we) begin
      w_q[cfg_addr] <= cfg_wdata;
    end
  end

  // Coupling uses registered spikes, so a spike reaches its targets one edge later.
  always_comb begin
    for (int i = 0; i < N_NEURONS; i++) begin
      syn[i] = '0;
      for (int j = 0; j < N_NEURONS; j++) begin
        if (j != i && spike_out[j]) syn[i] = syn[i] + SW'(w_q[widx(i, j, N_NEURONS)]);
      end
    end
  end

  for (genvar g = 0; g < N_NEURONS; g++) begin : g_neuron
    lif_neuron #(
      .V_WIDTH    (V_WIDTH),
      .SW         (SW),
      .THRESH     (THRESH),
      .LEAK_SHIFT (LEAK_SHIFT),
      .REFRAC     (REFRAC)
    ) u_neuron (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .bias       (bias_in[g*V_WIDTH +: V_WIDTH]),
      .syn_in     (syn[g]),
      .spike      (spike_out[g]),
      .spike_next (spike_next[g]),
      .v_out      (v_dbg[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   spike_count <= '0;
    else if (ena && |spike_next)  spike_count <= spike_count + 8'd1;
  end

  assign spike_any = |spike_out;

endmodule
